// File: rtl/mini16_board_pkg.sv
// ---------------------------------------------------------------------------
// mini16_board_pkg
//   Shared definitions for the board reset/PLL glue.
//   - seq_state_e   : reset sequencer state encoding (also driven on the
//                     seq_state debug/LED output)
//   - SEQ_STATE_BITS: width of the exported state
//   - clog2_min1    : $clog2 that never returns 0, for counter widths
// ---------------------------------------------------------------------------
package mini16_board_pkg;

   localparam int SEQ_STATE_BITS = 3;

   typedef enum logic [SEQ_STATE_BITS-1:0] {
      ST_IDLE    = 3'd0,
      ST_HOLD    = 3'd1,
      ST_RELEASE = 3'd2,
      ST_RUN     = 3'd3,
      ST_PLLRST  = 3'd4
   } seq_state_e;

   // A counter always needs at least one bit, even when its range is 0..0.
   function automatic int clog2_min1(input int value);
      return (value > 1) ? $clog2(value) : 1;
   endfunction

endpackage

// File: rtl/board_debounce.sv
// ---------------------------------------------------------------------------
// board_debounce
//   Synchronises one active-low push-button and debounces it.
//   Ports:
//     clk      in   system clock
//     reset    in   synchronous active-high reset
//     button_n in   raw button, active-low, asynchronous to clk
//     level    out  debounced state, 1 = pressed
//     press    out  one-cycle pulse when level goes 0->1
//   The synchronised input must disagree with level for 2^DEBOUNCE_BITS
//   consecutive cycles before level follows it; any agreement restarts the
//   count.
// ---------------------------------------------------------------------------
module board_debounce
   import mini16_board_pkg::*;
#(
   parameter int DEBOUNCE_BITS = 16
) (
   input  logic clk,
   input  logic reset,
   input  logic button_n,
   output logic level,
   output logic press
);

   localparam logic [DEBOUNCE_BITS-1:0] CNT_MAX = '1;

   logic                     btn_meta;
   logic                     btn_s;
   logic [DEBOUNCE_BITS-1:0] cnt;

   always_ff @(posedge clk) begin
      if (reset) begin
         btn_meta <= 1'b0;
         btn_s    <= 1'b0;
         cnt      <= '0;
         level    <= 1'b0;
         press    <= 1'b0;
      end else begin
         btn_meta <= ~button_n;
         btn_s    <= btn_meta;
         press    <= 1'b0;
         if (btn_s != level) begin
            if (cnt == CNT_MAX) begin
               level <= ~level;
               cnt   <= '0;
               // Pulse only on the 0->1 transition.
               press <= ~level;
            end else begin
               cnt <= cnt + 1'b1;
            end
         end else begin
            cnt <= '0;
         end
      end
   end

endmodule

// File: rtl/board_reset_sequencer.sv
// ---------------------------------------------------------------------------
// board_reset_sequencer
//   Board-level reset/PLL glue for mini16: synchronises and debounces the
//   push-buttons and PLL lock, lets button 0 request a PLL reset, and
//   releases NUM_RESETS domain resets in a staggered order once lock has
//   been stable for HOLD_CYCLES. Lock loss reasserts every reset and is
//   counted in a saturating counter.
//   Ports:
//     clk             in   system clock
//     reset           in   synchronous active-high power-on/global reset
//     pll_locked      in   PLL lock, asynchronous
//     button_n        in   raw buttons, active-low, asynchronous
//     reset_out       out  active-high domain resets, index 0 released first
//     pll_reset       out  active-high PLL reset request
//     button_level    out  debounced button state, 1 = pressed
//     button_press    out  one-cycle pulse per debounced press
//     lock_loss_count out  saturating lock-loss counter
//     seq_state       out  current sequencer state
//   All outputs come straight from flops.
// ---------------------------------------------------------------------------
module board_reset_sequencer
   import mini16_board_pkg::*;
#(
   parameter int NUM_RESETS     = 3,
   parameter int NUM_BUTTONS    = 2,
   parameter int DEBOUNCE_BITS  = 16,
   parameter int HOLD_CYCLES    = 1024,
   parameter int STAGGER        = 16,
   parameter int PLL_RST_CYCLES = 64,
   parameter int LOSS_CNT_BITS  = 8
) (
   input  logic                      clk,
   input  logic                      reset,
   input  logic                      pll_locked,
   input  logic [NUM_BUTTONS-1:0]    button_n,
   output logic [NUM_RESETS-1:0]     reset_out,
   output logic                      pll_reset,
   output logic [NUM_BUTTONS-1:0]    button_level,
   output logic [NUM_BUTTONS-1:0]    button_press,
   output logic [LOSS_CNT_BITS-1:0]  lock_loss_count,
   output logic [SEQ_STATE_BITS-1:0] seq_state
);

   localparam int HOLD_W   = clog2_min1(HOLD_CYCLES);
   localparam int REL_W    = clog2_min1(STAGGER * NUM_RESETS + 1);
   localparam int PLL_W    = clog2_min1(PLL_RST_CYCLES);
   localparam int LAST_REL = STAGGER * (NUM_RESETS - 1);

   localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(HOLD_CYCLES - 1);
   localparam logic [REL_W-1:0]  REL_LAST  = REL_W'(LAST_REL);
   localparam logic [PLL_W-1:0]  PLL_LAST  = PLL_W'(PLL_RST_CYCLES - 1);

   seq_state_e         state;
   logic               lock_meta;
   logic               lock_s;
   logic [HOLD_W-1:0]  hold_cnt;
   logic [REL_W-1:0]   rel_cnt;
   logic [REL_W-1:0]   rel_next;
   logic [PLL_W-1:0]   pll_cnt;
   logic               lock_lost;

   for (genvar b = 0; b < NUM_BUTTONS; b++) begin : g_btn
      board_debounce #(
         .DEBOUNCE_BITS(DEBOUNCE_BITS)
      ) u_debounce (
         .clk     (clk),
         .reset   (reset),
         .button_n(button_n[b]),
         .level   (button_level[b]),
         .press   (button_press[b])
      );
   end

   // rel_cnt counts cycles since reset_out[0] cleared; rel_next is the
   // value it holds after this edge.
   assign rel_next  = rel_cnt + 1'b1;
   assign lock_lost = ((state == ST_RELEASE) || (state == ST_RUN)) && !lock_s;
   assign seq_state = state;

   always_ff @(posedge clk) begin
      if (reset) begin
         lock_meta       <= 1'b0;
         lock_s          <= 1'b0;
         state           <= ST_IDLE;
         hold_cnt        <= '0;
         rel_cnt         <= '0;
         pll_cnt         <= '0;
         reset_out       <= '1;
         pll_reset       <= 1'b0;
         lock_loss_count <= '0;
      end else begin
         lock_meta <= pll_locked;
         lock_s    <= lock_meta;

         // A lock loss coinciding with a PLL reset request is still counted.
         if (lock_lost && (lock_loss_count != '1)) begin
            lock_loss_count <= lock_loss_count + 1'b1;
         end

         if (button_press[0] && (state != ST_PLLRST)) begin
            state     <= ST_PLLRST;
            pll_cnt   <= '0;
            pll_reset <= 1'b1;
            reset_out <= '1;
         end else begin
            case (state)
               ST_IDLE: begin
                  reset_out <= '1;
                  hold_cnt  <= '0;
                  if (lock_s) state <= ST_HOLD;
               end
               ST_HOLD: begin
                  if (!lock_s) begin
                     state    <= ST_IDLE;
                     hold_cnt <= '0;
                  end else if (hold_cnt == HOLD_LAST) begin
                     hold_cnt <= '0;
                     rel_cnt  <= '0;
                     if (LAST_REL == 0) begin
                        reset_out <= '0;
                        state     <= ST_RUN;
                     end else begin
                        reset_out[0] <= 1'b0;
                        state        <= ST_RELEASE;
                     end
                  end else begin
                     hold_cnt <= hold_cnt + 1'b1;
                  end
               end
               ST_RELEASE: begin
                  if (!lock_s) begin
                     reset_out <= '1;
                     state     <= ST_IDLE;
                  end else begin
                     rel_cnt <= rel_next;
                     // Bits already cleared stay cleared since rel_next only grows.
                     for (int i = 1; i < NUM_RESETS; i++) begin
                        if (rel_next >= REL_W'(i * STAGGER)) reset_out[i] <= 1'b0;
                     end
                     if (rel_next == REL_LAST) state <= ST_RUN;
                  end
               end
               ST_RUN: begin
                  if (!lock_s) begin
                     reset_out <= '1;
                     state     <= ST_IDLE;
                  end
               end
               ST_PLLRST: begin
                  reset_out <= '1;
                  if (pll_cnt == PLL_LAST) begin
                     pll_reset <= 1'b0;
                     state     <= ST_IDLE;
                  end else begin
                     pll_cnt <= pll_cnt + 1'b1;
                  end
               end
               default: begin
                  reset_out <= '1;
                  pll_reset <= 1'b0;
                  state     <= ST_IDLE;
               end
            endcase
         end
      end
   end

endmodule
